dds_seq_ctrl: RTL and testbench
===============================

// Module: dds_seq_ctrl
// PURPOSE
//  Sequencer for the TDM DDS core. Accepts a stream of config words and loads NUM_CH
//  thetas, then NUM_CH deltas, then NUM_CH amplitudes into the DDS shift-register FIFOs.
//  It then gates the DDS start (circulate) signal and emits a per-rotation frame tick.
//  Sits between the AXI config front-end and the DDS instance; owns every DDS control input.
// PARAMETERS
//  SIG_WIDTH  16      config word / DDS sample width
//  NUM_CH     16      DDS shift_reg depth (channels); must equal the DDS FIFO depth, >=2
//  THETAS     0       DDS address selecting the theta FIFO
//  DELTAS     1       DDS address selecting the delta FIFO
//  AMPLS      2       DDS address selecting the amplitude FIFO
//  IDLE_ADDR  9'h1FF  DDS address that enables no FIFO
// PORTS
//  clk              in   1              single clock
//  rst              in   1              synchronous, active-high reset
//  i_load_req       in   1              pulse: (re)start a full configuration load
//  i_run            in   1              level: allow DDS circulation once loaded
//  i_auto_run       in   1              1: enter RUN directly after load if i_run=1
//  s_cfg_valid      in   1              config stream valid
//  s_cfg_ready      out  1              config stream ready
//  s_cfg_data       in   SIG_WIDTH      config word (theta/delta/ampl, in load order)
//  o_dds_rst        out  1              to DDS i_dds_rst
//  o_dds_start      out  1              to DDS i_dds_start
//  o_dds_addrs      out  9              to DDS i_dds_addrs
//  o_dds_fifo_data  out  SIG_WIDTH      to DDS i_dds_fifo_data
//  o_busy           out  1              high in CLEAR/LOAD_*/FLUSH
//  o_loaded         out  1              FIFOs hold a complete config (READY or RUN)
//  o_ch_idx         out  $clog2(NUM_CH) channel currently circulated (RUN only, else 0)
//  o_frame_tick     out  1              1-cycle pulse on the last channel of each rotation
// BEHAVIOUR
//  States: IDLE, CLEAR, LOAD_TH, LOAD_DE, LOAD_AM, FLUSH, READY, RUN.
//  Reset: state=IDLE; o_dds_rst=0, o_dds_start=0, o_dds_addrs=IDLE_ADDR, o_dds_fifo_data=0,
//   s_cfg_ready=0, o_busy=0, o_loaded=0, o_ch_idx=0, o_frame_tick=0, word counter=0.
//  i_load_req from any state -> CLEAR. It has priority over every other transition.
//  CLEAR: exactly 1 cycle; o_dds_rst=1, o_loaded=0 -> LOAD_TH.
//  LOAD_x: s_cfg_ready=1. Each accepted word (valid&ready) increments the word counter.
//   The cycle after acceptance, the controller drives o_dds_addrs=x-address and
//   o_dds_fifo_data=word (registered). With no accept, it drives IDLE_ADDR.
//   After NUM_CH accepts: LOAD_TH->LOAD_DE->LOAD_AM, counter wraps to 0.
//  The last amplitude accept -> FLUSH. s_cfg_ready=0 in FLUSH; its only job is issuing
//   the final write.
//  FLUSH -> RUN if (i_auto_run & i_run), else READY.
//  READY: o_loaded=1; FIFOs hold. i_run=1 -> RUN.
//  RUN: o_dds_start=1 (decoded from state register), o_dds_addrs=IDLE_ADDR.
//   o_ch_idx counts 0..NUM_CH-1 and wraps; o_frame_tick=1 when o_ch_idx==NUM_CH-1.
//   i_run=0 -> READY. o_ch_idx returns to 0 and the FIFO rotation is frozen in place.
//  o_dds_start and a FIFO write are never high in the same cycle. o_dds_rst is never
//   high outside CLEAR.
//  s_cfg_ready=0 outside LOAD_*. Words presented then are not consumed.
//  Reload mid-load or mid-run: the partial config is discarded via CLEAR. The counter
//   restarts at 0.
//  rst asserted mid-operation: all outputs return to their reset values next edge. The
//   DDS FIFOs are not cleared by rst; they are cleared only via CLEAR.
// TESTING  (NUM_CH=4)
//  Load 12 words 0x10..0x1B, valid held high -> writes addr 0 x4, addr 1 x4, addr 2 x4,
//   one per cycle, data in order; FLUSH; o_loaded=1.
//  Same load with i_auto_run=1, i_run=1 -> o_dds_start rises the cycle after FLUSH.
//   o_frame_tick on ch 3, then every 4 cycles.
//  Valid toggled 1/0 during load -> 12 writes total; IDLE_ADDR on every gap cycle;
//   no start before the 12th write.
//  i_load_req after 5 words -> o_dds_rst for 1 cycle; next accepted word written to
//   addr 0; full 12 required.
//  RUN with i_run dropped at ch 2 then re-raised -> READY with start=0; on resume,
//   o_ch_idx restarts at 0.
//  rst during LOAD_DE and during RUN -> all outputs at reset values; s_cfg_ready=0;
//   state IDLE.

Source files
------------

// File: rtl/dds_seq_ctrl.sv
// Configuration sequencer for the TDM DDS core: streams thetas, deltas and amplitudes
// into the DDS shift-register FIFOs, then gates circulation and marks each rotation.
module dds_seq_ctrl #(
    parameter int unsigned SIG_WIDTH = 16,
    parameter int unsigned NUM_CH    = 16,
    parameter logic [8:0]  THETAS    = 9'd0,
    parameter logic [8:0]  DELTAS    = 9'd1,
    parameter logic [8:0]  AMPLS     = 9'd2,
    parameter logic [8:0]  IDLE_ADDR = 9'h1FF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load_req,
    input  logic                      i_run,
    input  logic                      i_auto_run,
    input  logic                      s_cfg_valid,
    output logic                      s_cfg_ready,
    input  logic [SIG_WIDTH-1:0]      s_cfg_data,
    output logic                      o_dds_rst,
    output logic                      o_dds_start,
    output logic [8:0]                o_dds_addrs,
    output logic [SIG_WIDTH-1:0]      o_dds_fifo_data,
    output logic                      o_busy,
    output logic                      o_loaded,
    output logic [$clog2(NUM_CH)-1:0] o_ch_idx,
    output logic                      o_frame_tick
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD_TH, S_LOAD_DE, S_LOAD_AM, S_FLUSH, S_READY, S_RUN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CH_W-1:0]      word_cnt;
    logic [CH_W-1:0]      cnt_d;
    logic [CH_W-1:0]      ch_d;
    logic [8:0]           addrs_d;
    logic [SIG_WIDTH-1:0] data_d;
    logic                 in_load_c;
    logic                 accept_c;
    logic                 last_word_c;

    assign in_load_c   = (state == S_LOAD_TH) || (state == S_LOAD_DE) || (state == S_LOAD_AM);
    assign accept_c    = in_load_c && s_cfg_valid;
    assign last_word_c = (word_cnt == LAST_CH);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a load request overrides every other transition
    always_comb begin
        state_nxt = state;
        if (i_load_req) begin
            state_nxt = S_CLEAR;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_IDLE;
                S_CLEAR:   state_nxt = S_LOAD_TH;
                S_LOAD_TH: if (accept_c && last_word_c) state_nxt = S_LOAD_DE;
                S_LOAD_DE: if (accept_c && last_word_c) state_nxt = S_LOAD_AM;
                S_LOAD_AM: if (accept_c && last_word_c) state_nxt = S_FLUSH;
                S_FLUSH:   state_nxt = (i_auto_run && i_run) ? S_RUN : S_READY;
                S_READY:   if (i_run) state_nxt = S_RUN;
                S_RUN:     if (!i_run) state_nxt = S_READY;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; an accepted word is written one cycle later
    always_comb begin
        cnt_d   = word_cnt;
        addrs_d = IDLE_ADDR;
        data_d  = o_dds_fifo_data;
        ch_d    = '0;
        if (i_load_req || state == S_CLEAR) begin
            cnt_d = '0;
        end else if (accept_c) begin
            cnt_d  = last_word_c ? '0 : word_cnt + CH_W'(1);
            data_d = s_cfg_data;
            case (state)
                S_LOAD_TH: addrs_d = THETAS;
                S_LOAD_DE: addrs_d = DELTAS;
                default:   addrs_d = AMPLS;
            endcase
        end
        if (state_nxt == S_RUN && state == S_RUN)
            ch_d = (o_ch_idx == LAST_CH) ? '0 : o_ch_idx + CH_W'(1);
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt        <= '0;
            s_cfg_ready     <= 1'b0;
            o_dds_rst       <= 1'b0;
            o_dds_start     <= 1'b0;
            o_dds_addrs     <= IDLE_ADDR;
            o_dds_fifo_data <= '0;
            o_busy          <= 1'b0;
            o_loaded        <= 1'b0;
            o_ch_idx        <= '0;
            o_frame_tick    <= 1'b0;
        end else begin
            word_cnt        <= cnt_d;
            s_cfg_ready     <= (state_nxt == S_LOAD_TH) || (state_nxt == S_LOAD_DE) ||
                               (state_nxt == S_LOAD_AM);
            o_dds_rst       <= (state_nxt == S_CLEAR);
            o_dds_start     <= (state_nxt == S_RUN);
            o_dds_addrs     <= addrs_d;
            o_dds_fifo_data <= data_d;
            o_busy          <= (state_nxt == S_CLEAR) || (state_nxt == S_LOAD_TH) ||
                               (state_nxt == S_LOAD_DE) || (state_nxt == S_LOAD_AM) ||
                               (state_nxt == S_FLUSH);
            o_loaded        <= (state_nxt == S_READY) || (state_nxt == S_RUN);
            o_ch_idx        <= ch_d;
            o_frame_tick    <= (state_nxt == S_RUN) && (ch_d == LAST_CH);
        end
    end

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Bench for dds_seq_ctrl (NUM_CH=4): directed scenarios then random soak, checked every
// cycle against a word-count based reference model.
module tb_dds_seq_ctrl;

    localparam int N    = 4;
    localparam int SW   = 16;
    localparam int CH_W = $clog2(N);
    localparam logic [8:0] IDLE_A = 9'h1FF;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_LOAD  = 2;
    localparam int M_FLUSH = 3;
    localparam int M_READY = 4;
    localparam int M_RUN   = 5;

    logic            clk;
    logic            rst;
    logic            i_load_req;
    logic            i_run;
    logic            i_auto_run;
    logic            s_cfg_valid;
    logic            s_cfg_ready;
    logic [SW-1:0]   s_cfg_data;
    logic            o_dds_rst;
    logic            o_dds_start;
    logic [8:0]      o_dds_addrs;
    logic [SW-1:0]   o_dds_fifo_data;
    logic            o_busy;
    logic            o_loaded;
    logic [CH_W-1:0] o_ch_idx;
    logic            o_frame_tick;

    dds_seq_ctrl #(.SIG_WIDTH(SW), .NUM_CH(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_load_req      (i_load_req),
        .i_run           (i_run),
        .i_auto_run      (i_auto_run),
        .s_cfg_valid     (s_cfg_valid),
        .s_cfg_ready     (s_cfg_ready),
        .s_cfg_data      (s_cfg_data),
        .o_dds_rst       (o_dds_rst),
        .o_dds_start     (o_dds_start),
        .o_dds_addrs     (o_dds_addrs),
        .o_dds_fifo_data (o_dds_fifo_data),
        .o_busy          (o_busy),
        .o_loaded        (o_loaded),
        .o_ch_idx        (o_ch_idx),
        .o_frame_tick    (o_frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase, total words accepted since the last clear, cycles spent running
    int            m_mode = M_IDLE;
    int            m_nw   = 0;
    int            m_rc   = 0;
    bit            m_wr   = 1'b0;
    bit            m_acc  = 1'b0;
    logic [8:0]    m_wa   = 9'd0;
    logic [SW-1:0] m_wd   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model with the current inputs, clock once, then compare every output
    task automatic tick();
        m_wr  = 1'b0;
        m_acc = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
            m_nw   = 0;
            m_rc   = 0;
        end else if (i_load_req) begin
            m_mode = M_CLEAR;
            m_nw   = 0;
        end else begin
            case (m_mode)
                M_CLEAR: m_mode = M_LOAD;
                M_LOAD: if (s_cfg_valid) begin
                    m_wr  = 1'b1;
                    m_acc = 1'b1;
                    m_wa  = 9'(m_nw / N);
                    m_wd  = s_cfg_data;
                    m_nw++;
                    if (m_nw == 3 * N) m_mode = M_FLUSH;
                end
                M_FLUSH: begin
                    m_mode = (i_auto_run && i_run) ? M_RUN : M_READY;
                    m_rc   = 0;
                end
                M_READY: if (i_run) begin
                    m_mode = M_RUN;
                    m_rc   = 0;
                end
                M_RUN: if (!i_run) m_mode = M_READY; else m_rc++;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        chk("cfg_ready", 32'(s_cfg_ready), 32'(m_mode == M_LOAD));
        chk("dds_rst",   32'(o_dds_rst),   32'(m_mode == M_CLEAR));
        chk("dds_start", 32'(o_dds_start), 32'(m_mode == M_RUN));
        chk("busy",      32'(o_busy),
            32'(m_mode == M_CLEAR || m_mode == M_LOAD || m_mode == M_FLUSH));
        chk("loaded",    32'(o_loaded),    32'(m_mode == M_READY || m_mode == M_RUN));
        chk("dds_addrs", 32'(o_dds_addrs), m_wr ? 32'(m_wa) : 32'(IDLE_A));
        if (m_wr) chk("fifo_data", 32'(o_dds_fifo_data), 32'(m_wd));
        chk("ch_idx",     32'(o_ch_idx),     (m_mode == M_RUN) ? 32'(m_rc % N) : 32'd0);
        chk("frame_tick", 32'(o_frame_tick), 32'(m_mode == M_RUN && (m_rc % N) == N - 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulse a load request, then present words until the model has accepted `total`
    task automatic load_cfg(input int total, input bit toggle, input bit seq_data);
        int acc;
        int guard;
        acc   = 0;
        guard = 0;
        i_load_req = 1'b1;
        tick();
        i_load_req = 1'b0;
        while (acc < total && guard < 8 * total + 10) begin
            s_cfg_valid = toggle ? ((guard % 2) == 0) : 1'b1;
            s_cfg_data  = seq_data ? SW'(16'h10 + acc) : SW'($urandom);
            tick();
            if (m_acc) acc++;
            guard++;
        end
        s_cfg_valid = 1'b0;
        chk("load_words", 32'(acc), 32'(total));
    endtask

    initial begin
        rst         = 1'b1;
        i_load_req  = 1'b0;
        i_run       = 1'b0;
        i_auto_run  = 1'b0;
        s_cfg_valid = 1'b1;
        s_cfg_data  = 16'hABCD;
        idle(2);
        rst = 1'b0;
        idle(3);

        // Plain load, sequential data, ends in READY
        load_cfg(3 * N, 1'b0, 1'b1);
        idle(4);
        i_run = 1'b1;
        idle(9);
        i_run = 1'b0;
        idle(2);

        // Auto-run load; then drop run at channel 2 and resume
        i_auto_run = 1'b1;
        i_run      = 1'b1;
        load_cfg(3 * N, 1'b0, 1'b1);
        idle(10);
        for (int i = 0; i < 8 && !(m_mode == M_RUN && (m_rc % N) == 2); i++) tick();
        i_run = 1'b0;
        idle(3);
        i_run = 1'b1;
        idle(7);

        // Valid toggling during load, with auto-run armed
        load_cfg(3 * N, 1'b1, 1'b0);
        idle(6);

        // Reload after 5 words, then a full load
        load_cfg(5, 1'b0, 1'b0);
        load_cfg(3 * N, 1'b0, 1'b0);
        idle(3);

        // Reset during delta load, then during run
        load_cfg(N + 2, 1'b0, 1'b0);
        s_cfg_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);
        s_cfg_valid = 1'b0;
        load_cfg(3 * N, 1'b0, 1'b0);
        idle(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);

        // Random soak
        for (int i = 0; i < 2000; i++) begin
            i_load_req  = ($urandom_range(0, 59) == 0);
            rst         = ($urandom_range(0, 249) == 0);
            s_cfg_valid = 1'($urandom_range(0, 1));
            s_cfg_data  = SW'($urandom);
            if ($urandom_range(0, 9) == 0) i_run = ~i_run;
            if (i_load_req) i_auto_run = 1'($urandom_range(0, 1));
            tick();
        end
        rst        = 1'b0;
        i_load_req = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
